// File: rtl/boot_loader_if.sv
// Bus bundle for the boot loader: start/done handshake plus the ROM, main
// memory, IM and DM ports. The boot loader drives through the master
// modport; the surrounding memories and system control use the slave view.
interface boot_loader_if #(
    parameter int ROM_AW = 8,
    parameter int MEM_AW = 16,
    parameter int IM_AW  = 10,
    parameter int DM_AW  = 12,
    parameter int DW     = 32
);
    localparam int DESC_W = 1 + MEM_AW + DM_AW + 8;

    logic                system_enable;
    logic                rom_done;

    logic                rom_enable;
    logic                rom_read;
    logic [ROM_AW-1:0]   rom_address;
    logic [DESC_W-1:0]   rom_out;

    logic                MEM_en;
    logic                MEM_read;
    logic                MEM_write;
    logic [MEM_AW-1:0]   MEM_addr;
    logic [DW-1:0]       MEM_data;

    logic                IM_enable;
    logic                IM_write;
    logic [IM_AW-1:0]    IM_address;
    logic [DW-1:0]       IM_in;

    logic                DM_enable;
    logic                DM_write;
    logic [DM_AW-1:0]    DM_address;
    logic [DW-1:0]       DM_in;

    modport master (
        input  system_enable, rom_out, MEM_data,
        output rom_done,
        output rom_enable, rom_read, rom_address,
        output MEM_en, MEM_read, MEM_write, MEM_addr,
        output IM_enable, IM_write, IM_address, IM_in,
        output DM_enable, DM_write, DM_address, DM_in
    );

    modport slave (
        output system_enable, rom_out, MEM_data,
        input  rom_done,
        input  rom_enable, rom_read, rom_address,
        input  MEM_en, MEM_read, MEM_write, MEM_addr,
        input  IM_enable, IM_write, IM_address, IM_in,
        input  DM_enable, DM_write, DM_address, DM_in
    );
endinterface

// File: rtl/boot_loader.sv
// Boot-time copy engine. Walks the descriptor table in the boot ROM and
// copies each described block from main memory into IM or DM, then raises a
// sticky rom_done that releases the core.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for system_enable
// S_ROM_REQ  | rom_read strobe for descriptor idx
// S_ROM_WAIT | ROM access latency
// S_DECODE   | latch descriptor; zero count is the end-of-table marker
// S_MEM_REQ  | MEM_read strobe at src
// S_MEM_WAIT | main-memory access latency
// S_WRITE    | one-cycle IM/DM write pulse, advance src/dst/count
// S_DONE     | boot complete, rom_done held until reset
//
// Every output is a register loaded from the next-state view, so a strobe is
// high exactly during the state it belongs to.
module boot_loader #(
    parameter int ROM_AW = 8,
    parameter int MEM_AW = 16,
    parameter int IM_AW  = 10,
    parameter int DM_AW  = 12,
    parameter int DW     = 32
) (
    input  logic          clk,
    input  logic          rst,
    boot_loader_if.master bus
);
    localparam int CNT_W   = 8;
    localparam int DESC_W  = 1 + MEM_AW + DM_AW + CNT_W;
    localparam int SRC_LSB = DM_AW + CNT_W;
    localparam int DST_LSB = CNT_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROM_REQ,
        S_ROM_WAIT,
        S_DECODE,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state, state_n;

    // descriptor working registers
    logic              tgt_q, tgt_n;
    logic [MEM_AW-1:0] src_q, src_n;
    logic [DM_AW-1:0]  dst_q, dst_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [ROM_AW-1:0] idx_q, idx_n;

    // registered outputs
    logic              rom_enable_q,  rom_enable_n;
    logic              rom_read_q,    rom_read_n;
    logic [ROM_AW-1:0] rom_address_q, rom_address_n;
    logic              mem_en_q,      mem_en_n;
    logic              mem_read_q,    mem_read_n;
    logic [MEM_AW-1:0] mem_addr_q,    mem_addr_n;
    logic              im_enable_q,   im_enable_n;
    logic              im_write_q,    im_write_n;
    logic [IM_AW-1:0]  im_address_q,  im_address_n;
    logic [DW-1:0]     im_in_q,       im_in_n;
    logic              dm_enable_q,   dm_enable_n;
    logic              dm_write_q,    dm_write_n;
    logic [DM_AW-1:0]  dm_address_q,  dm_address_n;
    logic [DW-1:0]     dm_in_q,       dm_in_n;
    logic              rom_done_q,    rom_done_n;

    logic last_word;
    logic last_desc;
    logic desc_is_end;

    assign last_word   = (cnt_q == CNT_W'(1));
    assign last_desc   = (idx_q == {ROM_AW{1'b1}});
    assign desc_is_end = (bus.rom_out[CNT_W-1:0] == '0);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode; descriptor 255 never wraps the index back to 0.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:     if (bus.system_enable) state_n = S_ROM_REQ;
            S_ROM_REQ:  state_n = S_ROM_WAIT;
            S_ROM_WAIT: state_n = S_DECODE;
            S_DECODE:   state_n = desc_is_end ? S_DONE : S_MEM_REQ;
            S_MEM_REQ:  state_n = S_MEM_WAIT;
            S_MEM_WAIT: state_n = S_WRITE;
            S_WRITE: begin
                if (!last_word)     state_n = S_MEM_REQ;
                else if (last_desc) state_n = S_DONE;
                else                state_n = S_ROM_REQ;
            end
            S_DONE:     state_n = S_DONE;
            default:    state_n = S_IDLE;
        endcase
    end

    // Datapath updates and next values of the registered outputs.
    always_comb begin
        tgt_n = tgt_q;
        src_n = src_q;
        dst_n = dst_q;
        cnt_n = cnt_q;
        idx_n = idx_q;

        if (state == S_DECODE) begin
            tgt_n = bus.rom_out[DESC_W-1];
            src_n = bus.rom_out[SRC_LSB +: MEM_AW];
            dst_n = bus.rom_out[DST_LSB +: DM_AW];
            cnt_n = bus.rom_out[CNT_W-1:0];
        end else if (state == S_WRITE) begin
            // Full-width dst increment; IM only sees the low bits, so the
            // IM wrap at 2^IM_AW comes for free.
            src_n = src_q + MEM_AW'(1);
            dst_n = dst_q + DM_AW'(1);
            cnt_n = cnt_q - CNT_W'(1);
            if (last_word && !last_desc) begin
                idx_n = idx_q + ROM_AW'(1);
            end
        end

        rom_enable_n  = (state_n == S_ROM_REQ);
        rom_read_n    = (state_n == S_ROM_REQ);
        rom_address_n = (state_n == S_ROM_REQ) ? idx_n : rom_address_q;

        mem_en_n      = (state_n == S_MEM_REQ);
        mem_read_n    = (state_n == S_MEM_REQ);
        mem_addr_n    = (state_n == S_MEM_REQ) ? src_n : mem_addr_q;

        im_enable_n   = (state_n == S_WRITE) && !tgt_q;
        im_write_n    = im_enable_n;
        im_address_n  = im_enable_n ? dst_q[IM_AW-1:0] : im_address_q;
        im_in_n       = im_enable_n ? bus.MEM_data : im_in_q;

        dm_enable_n   = (state_n == S_WRITE) && tgt_q;
        dm_write_n    = dm_enable_n;
        dm_address_n  = dm_enable_n ? dst_q : dm_address_q;
        dm_in_n       = dm_enable_n ? bus.MEM_data : dm_in_q;

        rom_done_n    = (state_n == S_DONE);
    end

    // Datapath and output registers; reset clears everything at once so an
    // interrupted copy issues no further writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tgt_q         <= 1'b0;
            src_q         <= '0;
            dst_q         <= '0;
            cnt_q         <= '0;
            idx_q         <= '0;
            rom_enable_q  <= 1'b0;
            rom_read_q    <= 1'b0;
            rom_address_q <= '0;
            mem_en_q      <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_addr_q    <= '0;
            im_enable_q   <= 1'b0;
            im_write_q    <= 1'b0;
            im_address_q  <= '0;
            im_in_q       <= '0;
            dm_enable_q   <= 1'b0;
            dm_write_q    <= 1'b0;
            dm_address_q  <= '0;
            dm_in_q       <= '0;
            rom_done_q    <= 1'b0;
        end else begin
            tgt_q         <= tgt_n;
            src_q         <= src_n;
            dst_q         <= dst_n;
            cnt_q         <= cnt_n;
            idx_q         <= idx_n;
            rom_enable_q  <= rom_enable_n;
            rom_read_q    <= rom_read_n;
            rom_address_q <= rom_address_n;
            mem_en_q      <= mem_en_n;
            mem_read_q    <= mem_read_n;
            mem_addr_q    <= mem_addr_n;
            im_enable_q   <= im_enable_n;
            im_write_q    <= im_write_n;
            im_address_q  <= im_address_n;
            im_in_q       <= im_in_n;
            dm_enable_q   <= dm_enable_n;
            dm_write_q    <= dm_write_n;
            dm_address_q  <= dm_address_n;
            dm_in_q       <= dm_in_n;
            rom_done_q    <= rom_done_n;
        end
    end

    assign bus.rom_enable  = rom_enable_q;
    assign bus.rom_read    = rom_read_q;
    assign bus.rom_address = rom_address_q;
    assign bus.MEM_en      = mem_en_q;
    assign bus.MEM_read    = mem_read_q;
    assign bus.MEM_write   = 1'b0;
    assign bus.MEM_addr    = mem_addr_q;
    assign bus.IM_enable   = im_enable_q;
    assign bus.IM_write    = im_write_q;
    assign bus.IM_address  = im_address_q;
    assign bus.IM_in       = im_in_q;
    assign bus.DM_enable   = dm_enable_q;
    assign bus.DM_write    = dm_write_q;
    assign bus.DM_address  = dm_address_q;
    assign bus.DM_in       = dm_in_q;
    assign bus.rom_done    = rom_done_q;
endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: synchronous ROM / main-memory responders, IM/DM
// capture, and a descriptor-level reference model that predicts the write
// list, the MEM read addresses, the ROM index sequence and the boot length.
module tb_boot_loader;
    logic clk = 1'b0;
    logic rst;

    boot_loader_if bus ();

    boot_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit        dm;
        bit [11:0] addr;
        bit [31:0] data;
    } wr_t;

    bit [36:0] rom    [256];
    bit [31:0] mem    [65536];
    bit [31:0] im_cap [1024];
    bit [31:0] dm_cap [4096];

    int wr_count;
    int mem_rd_count;
    int checks;
    int errors;

    wr_t      exp_wr  [$];
    bit [15:0] exp_rd [$];
    bit [7:0] exp_idx [$];
    int       exp_cycles;
    int       exp_writes;
    int       exp_reads;

    bit checking;
    bit sim_done;

    // Memory responders: data appears the cycle after enable+read.
    always @(posedge clk) begin
        if (bus.rom_enable && bus.rom_read) bus.rom_out <= rom[bus.rom_address];
        if (bus.MEM_en && bus.MEM_read) begin
            bus.MEM_data <= mem[bus.MEM_addr];
            mem_rd_count <= mem_rd_count + 1;
        end
    end

    // IM/DM capture.
    always @(posedge clk) begin
        if (bus.IM_enable && bus.IM_write) im_cap[bus.IM_address] <= bus.IM_in;
        if (bus.DM_enable && bus.DM_write) dm_cap[bus.DM_address] <= bus.DM_in;
        wr_count <= wr_count + int'(bus.IM_enable && bus.IM_write)
                             + int'(bus.DM_enable && bus.DM_write);
    end

    task automatic check(input string nm, input bit ok,
                         input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic bit outs_zero();
        return !(bus.rom_enable || bus.rom_read || (|bus.rom_address) ||
                 bus.MEM_en || bus.MEM_read || bus.MEM_write || (|bus.MEM_addr) ||
                 bus.IM_enable || bus.IM_write || (|bus.IM_address) || (|bus.IM_in) ||
                 bus.DM_enable || bus.DM_write || (|bus.DM_address) || (|bus.DM_in) ||
                 bus.rom_done);
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = '0;
    endtask

    // Descriptor-level model of a whole boot.
    task automatic build_model();
        bit [36:0] d;
        bit [7:0]  cnt;
        bit [15:0] s;
        bit [11:0] a;
        wr_t       w;
        exp_wr.delete();
        exp_rd.delete();
        exp_idx.delete();
        exp_cycles = 0;
        for (int i = 0; i < 256; i++) begin
            d   = rom[i];
            cnt = d[7:0];
            exp_idx.push_back(8'(i));
            exp_cycles += 3;
            if (cnt == 0) break;
            for (int k = 0; k < int'(cnt); k++) begin
                s = 16'(int'(d[35:20]) + k);
                if (d[36]) a = 12'(int'(d[19:8]) + k);
                else       a = {2'b00, 10'(int'(d[19:8]) + k)};
                exp_rd.push_back(s);
                w.dm   = d[36];
                w.addr = a;
                w.data = mem[s];
                exp_wr.push_back(w);
                exp_cycles += 3;
            end
        end
        exp_writes = exp_wr.size();
        exp_reads  = exp_rd.size();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_state", outs_zero(), 64'(bus.rom_done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // One boot from IDLE. With abort_after > 0, reset is asserted mid-cycle
    // once that many writes have happened.
    task automatic run_boot(input int abort_after, output int cyc,
                            output int nwr, output int nrd);
        int n;
        int w0;
        int r0;
        bit done_seen;
        build_model();
        w0 = wr_count;
        r0 = mem_rd_count;
        cyc = 0; nwr = 0; nrd = 0;
        checking = 1'b1;
        @(negedge clk);
        bus.system_enable = 1'b1;
        @(negedge clk);
        bus.system_enable = 1'b0;
        if (abort_after > 0) begin
            n = 0;
            while ((wr_count - w0) < abort_after && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("abort_wait", (wr_count - w0) >= abort_after, 64'(wr_count - w0), 64'(abort_after));
            #3;
            checking = 1'b0;
            rst = 1'b0;
            #1;
            check("async_reset", outs_zero(), 64'(bus.MEM_en), 0);
            w0 = wr_count;
            repeat (3) @(posedge clk);
            #1;
            check("no_write_in_reset", wr_count == w0, 64'(wr_count), 64'(w0));
            check("held_in_reset", outs_zero(), 64'(bus.rom_read), 0);
            @(negedge clk);
            rst = 1'b1;
            return;
        end
        n = 0;
        done_seen = 1'b0;
        while (!done_seen && n < exp_cycles + 100) begin
            @(posedge clk);
            #1;
            n++;
            done_seen = bus.rom_done;
        end
        check("done_seen", done_seen, 64'(done_seen), 1);
        check("done_cycles", n == exp_cycles, 64'(n), 64'(exp_cycles));
        repeat (5) @(negedge clk);
        check("queues_drained", exp_wr.size() == 0 && exp_rd.size() == 0 && exp_idx.size() == 0,
              64'(exp_wr.size() + exp_rd.size() + exp_idx.size()), 0);
        check("done_sticky", bus.rom_done == 1'b1, 64'(bus.rom_done), 1);
        check("write_count", (wr_count - w0) == exp_writes, 64'(wr_count - w0), 64'(exp_writes));
        check("read_count", (mem_rd_count - r0) == exp_reads, 64'(mem_rd_count - r0), 64'(exp_reads));
        checking = 1'b0;
        cyc = n;
        nwr = wr_count - w0;
        nrd = mem_rd_count - r0;
    endtask

    initial begin
        rst = 1'b0;
        bus.system_enable = 1'b0;
        checking = 1'b0;
        sim_done = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        repeat (3) @(negedge clk);
        check("reset_initial", outs_zero(), 64'(bus.rom_done), 0);
        rst = 1'b1;

        fork
            begin : main_seq
                int cyc, nwr, nrd;

                // Single IM block then terminator.
                clear_rom();
                mem[16'h0100] = 32'hAAAA_0001;
                mem[16'h0101] = 32'hBBBB_0002;
                mem[16'h0102] = 32'hCCCC_0003;
                mem[16'h0103] = 32'hDDDD_0004;
                rom[0] = {1'b0, 16'h0100, 12'h080, 8'd4};
                run_boot(0, cyc, nwr, nrd);
                check("t1_cycles", cyc == 18, 64'(cyc), 18);
                check("t1_im80", im_cap[10'h080] == 32'hAAAA_0001, 64'(im_cap[10'h080]), 64'h AAAA_0001);
                check("t1_im83", im_cap[10'h083] == 32'hDDDD_0004, 64'(im_cap[10'h083]), 64'h DDDD_0004);
                check("t1_mem_write", bus.MEM_write == 1'b0, 64'(bus.MEM_write), 0);

                // DM block plus IM block wrapping at the top of IM.
                do_reset();
                clear_rom();
                rom[0] = {1'b1, 16'h0200, 12'h000, 8'd3};
                rom[1] = {1'b0, 16'h0000, 12'h3FF, 8'd2};
                run_boot(0, cyc, nwr, nrd);
                check("t2_writes", nwr == 5, 64'(nwr), 5);
                check("t2_im3ff", im_cap[10'h3FF] == mem[16'h0000], 64'(im_cap[10'h3FF]), 64'(mem[16'h0000]));
                check("t2_im000", im_cap[10'h000] == mem[16'h0001], 64'(im_cap[10'h000]), 64'(mem[16'h0001]));
                check("t2_dm002", dm_cap[12'h002] == mem[16'h0202], 64'(dm_cap[12'h002]), 64'(mem[16'h0202]));

                // Empty table.
                do_reset();
                clear_rom();
                run_boot(0, cyc, nwr, nrd);
                check("t3_cycles", cyc == 3, 64'(cyc), 3);
                check("t3_writes", nwr == 0, 64'(nwr), 0);
                check("t3_no_mem", nrd == 0, 64'(nrd), 0);

                // Source and DM destination wrap.
                do_reset();
                clear_rom();
                rom[0] = {1'b1, 16'hFFFF, 12'hFFF, 8'd2};
                run_boot(0, cyc, nwr, nrd);
                check("t4_dmfff", dm_cap[12'hFFF] == mem[16'hFFFF], 64'(dm_cap[12'hFFF]), 64'(mem[16'hFFFF]));
                check("t4_dm000", dm_cap[12'h000] == mem[16'h0000], 64'(dm_cap[12'h000]), 64'(mem[16'h0000]));
                check("t4_cycles", cyc == 12, 64'(cyc), 12);

                // Reset during the second word, then a clean reboot.
                do_reset();
                clear_rom();
                rom[0] = {1'b0, 16'h0300, 12'h010, 8'd4};
                run_boot(1, cyc, nwr, nrd);
                run_boot(0, cyc, nwr, nrd);
                check("t5_cycles", cyc == 18, 64'(cyc), 18);
                check("t5_im013", im_cap[10'h013] == mem[16'h0303], 64'(im_cap[10'h013]), 64'(mem[16'h0303]));

                // Full table, no terminator.
                do_reset();
                for (int i = 0; i < 256; i++)
                    rom[i] = {1'($urandom), 16'($urandom), 12'($urandom), 8'd1};
                run_boot(0, cyc, nwr, nrd);
                check("t6_writes", nwr == 256, 64'(nwr), 256);
                check("t6_cycles", cyc == 1536, 64'(cyc), 1536);
                check("t6_last_index", bus.rom_address == 8'd255, 64'(bus.rom_address), 255);

                // Maximum count.
                do_reset();
                clear_rom();
                rom[0] = {1'b0, 16'h8000, 12'h100, 8'd255};
                run_boot(0, cyc, nwr, nrd);
                check("t7_writes", nwr == 255, 64'(nwr), 255);
                check("t7_cycles", cyc == 771, 64'(cyc), 771);

                // Random tables.
                for (int t = 0; t < 8; t++) begin
                    int nd;
                    do_reset();
                    clear_rom();
                    nd = $urandom_range(1, 5);
                    for (int i = 0; i < nd; i++)
                        rom[i] = {1'($urandom), 16'($urandom), 12'($urandom),
                                  8'($urandom_range(1, 6))};
                    run_boot(0, cyc, nwr, nrd);
                end

                sim_done = 1'b1;
            end
            begin : compare
                while (!sim_done) begin
                    @(negedge clk);
                    if (checking) begin
                        int  s;
                        bit  ok;
                        wr_t act;
                        wr_t e;
                        s = int'(bus.rom_read) + int'(bus.MEM_read) +
                            int'(bus.IM_write) + int'(bus.DM_write);
                        ok = (s <= 1) && (bus.rom_enable == bus.rom_read) &&
                             (bus.MEM_en == bus.MEM_read) && (bus.IM_enable == bus.IM_write) &&
                             (bus.DM_enable == bus.DM_write) && !bus.MEM_write &&
                             !(bus.rom_done && s != 0);
                        check("strobes", ok,
                              64'({bus.rom_done, bus.rom_enable, bus.rom_read, bus.MEM_en, bus.MEM_read,
                                   bus.MEM_write, bus.IM_enable, bus.IM_write, bus.DM_enable, bus.DM_write}), 0);
                        if (bus.rom_read) begin
                            if (exp_idx.size() == 0) check("rom_index_extra", 1'b0, 64'(bus.rom_address), 0);
                            else begin
                                e.addr = 12'(exp_idx.pop_front());
                                check("rom_index", 12'(bus.rom_address) == e.addr, 64'(bus.rom_address), 64'(e.addr));
                            end
                        end
                        if (bus.MEM_read) begin
                            if (exp_rd.size() == 0) check("mem_read_extra", 1'b0, 64'(bus.MEM_addr), 0);
                            else begin
                                bit [15:0] ea;
                                ea = exp_rd.pop_front();
                                check("mem_addr", bus.MEM_addr == ea, 64'(bus.MEM_addr), 64'(ea));
                            end
                        end
                        if (bus.IM_write || bus.DM_write) begin
                            act.dm   = bus.DM_write;
                            act.addr = bus.DM_write ? bus.DM_address : {2'b00, bus.IM_address};
                            act.data = bus.DM_write ? bus.DM_in : bus.IM_in;
                            if (exp_wr.size() == 0) check("write_extra", 1'b0, 64'(act), 0);
                            else begin
                                e = exp_wr.pop_front();
                                check("write", act == e, 64'(act), 64'(e));
                            end
                        end
                    end
                end
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Boot-time copy engine that sits upstream of IM and DM, between the boot ROM and the main memory on one side and the instruction/data memories on the other.
- After `system_enable`, it walks a descriptor table in the 256-entry ROM. Each descriptor is copied from main memory into IM or DM.
- On finishing, it raises `rom_done`, which releases the core to fetch from IM.

Parameters:
- ROM_AW, 8, ROM address width (256 descriptors)
- MEM_AW, 16, main-memory address width
- IM_AW, 10, IM address width
- DM_AW, 12, DM address width
- DW, 32, data word width

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- system_enable  input  1  start request, sampled only in IDLE
- rom_enable  output  1  ROM enable
- rom_read  output  1  ROM read strobe
- rom_address  output  ROM_AW  descriptor index
- rom_out  input  37  descriptor: [36] target (0=IM, 1=DM), [35:20] source MEM address, [19:8] destination address, [7:0] word count
- MEM_en  output  1  main-memory enable
- MEM_read  output  1  main-memory read strobe
- MEM_write  output  1  main-memory write strobe, constant 0
- MEM_addr  output  MEM_AW  source word address
- MEM_data  input  DW  main-memory read data
- IM_enable  output  1  IM enable
- IM_write  output  1  IM write strobe
- IM_address  output  IM_AW  IM write address
- IM_in  output  DW  IM write data
- DM_enable  output  1  DM enable
- DM_write  output  1  DM write strobe
- DM_address  output  DM_AW  DM write address
- DM_in  output  DW  DM write data
- rom_done  output  1  boot complete, sticky

Behaviour:
- Reset (`rst`=0, asynchronous):
  - state IDLE, descriptor index 0.
  - all outputs 0, including `rom_done`.
  - Reset asserted mid-copy aborts immediately with no further writes; the next boot restarts at descriptor 0.
- All outputs are registered. ROM and MEM are synchronous: data is valid on `rom_out`/`MEM_data` the cycle after enable+read are asserted.
- States:
  - IDLE: `system_enable`=1 -> ROM_REQ.
  - ROM_REQ: assert `rom_enable`, `rom_read`, `rom_address`=index -> ROM_WAIT.
  - ROM_WAIT: -> DECODE.
  - DECODE: latch target, source, destination and count from `rom_out`.
    - count==0 is the end marker -> DONE.
    - otherwise -> MEM_REQ.
  - MEM_REQ: assert `MEM_en`, `MEM_read`, `MEM_addr`=src -> MEM_WAIT.
  - MEM_WAIT: -> WRITE.
  - WRITE: one-cycle write pulse.
    - Target IM: `IM_enable`, `IM_write`, `IM_address`=dst[IM_AW-1:0], `IM_in`=`MEM_data`.
    - Target DM: `DM_enable`, `DM_write`, `DM_address`=dst, `DM_in`=`MEM_data`.
    - Then src+1 and dst+1; count-1.
    - If the remaining count is 0: index+1 -> ROM_REQ. Otherwise -> MEM_REQ.
  - DONE: `rom_done`=1, all strobes 0; held until reset.
- Timing:
  - 3 cycles per copied word; 3 cycles per descriptor fetch.
  - An N-word descriptor costs 3+3N cycles. The terminator costs 3 cycles.
- Arithmetic and wrap-around:
  - src increments mod 2^16.
  - dst increments mod 2^12 for DM and mod 2^10 for IM; bits [11:10] are ignored for IM.
  - count 255 copies 255 words.
- Table end: if descriptor 255 is non-terminating, the block goes to DONE after completing it; the index never wraps to 0.
- `system_enable` deasserted mid-boot is ignored; the boot runs to DONE.
- Strobes are mutually exclusive. IM and DM strobes are never asserted in the same cycle, and never together with `rom_read`/`MEM_read`.
- Enables are 0 outside their active state. Address and data outputs hold their last value.

Test Plan:
- Descriptor 0 = {IM, src 0x0100, dst 0x080, cnt 4}, descriptor 1 = terminator; MEM[0x100..0x103]=A,B,C,D -> IM[0x80..0x83]=A..D; `rom_done` rises 3+12+3=18 cycles after leaving IDLE.
- Descriptors {DM, src 0x0200, dst 0x000, cnt 3}, {IM, src 0x0000, dst 0x3FF, cnt 2}, terminator -> DM[0..2] loaded; IM writes go to 0x3FF then 0x000 (IM wrap); exactly 5 write pulses in total.
- Descriptor 0 = terminator -> zero IM/DM writes; `rom_done`=1 after 3 cycles; MEM never enabled.
- Source at 0xFFFF with cnt 2 -> reads MEM[0xFFFF] then MEM[0x0000]; DM destination 0xFFF with cnt 2 -> writes DM[0xFFF] then DM[0x000].
- Drive `rst`=0 asynchronously during the 2nd word of a 4-word copy -> all outputs 0 before the next edge; after release plus `system_enable`, the copy restarts at descriptor 0 and completes.
- All 256 descriptors cnt 1, no terminator -> exactly 256 writes; `rom_done` after index 255; `rom_address` never returns to 0.
